// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative unsigned multiply / divide / modulo unit.
//
// Takes WIDTH cycles per operation (shift-add multiply, restoring division) and returns the
// result through a start/busy/done handshake. A divide or modulo by zero skips the
// iteration phase and completes on the accepting edge.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   operand1  multiplicand / dividend
//   operand2  multiplier / divisor
//   MUL_e     select low WIDTH bits of the product (highest priority)
//   DIV_e     select quotient
//   MOD_e     select remainder (lowest priority)
//   start     request, sampled on the rising edge
//   busy      high while iterating
//   done      one-cycle pulse when result becomes valid
//   result    registered result, held until the next completion
module mul_div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] operand1,
   input  logic [WIDTH-1:0] operand2,
   input  logic             MUL_e,
   input  logic             DIV_e,
   input  logic             MOD_e,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [1:0] OP_MUL = 2'd0;
   localparam logic [1:0] OP_DIV = 2'd1;
   localparam logic [1:0] OP_MOD = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [1:0]         op_q, op_d;
   // a: multiplicand or divisor. b: multiplier (shifted right) or dividend/quotient
   // (shifted left, quotient bits entering at the LSB). acc: product or remainder.
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   result_q, result_d;

   logic [2*WIDTH-1:0] addend;
   logic [2*WIDTH-1:0] mul_acc;
   logic [WIDTH:0]     rem_shift;
   logic [WIDTH:0]     rem_diff;
   logic [WIDTH:0]     rem_next;
   logic [WIDTH-1:0]   quo_next;
   logic               accept;

   // One iteration of each algorithm.
   always_comb begin
      addend    = b_q[0] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
      mul_acc   = acc_q + addend;
      rem_shift = {acc_q[WIDTH-1:0], b_q[WIDTH-1]};
      rem_diff  = rem_shift - {1'b0, a_q};
      // Borrow out of the trial subtraction means restore.
      rem_next  = rem_diff[WIDTH] ? rem_shift : rem_diff;
      quo_next  = {b_q[WIDTH-2:0], ~rem_diff[WIDTH]};
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      result_d = result_q;
      accept   = start && (MUL_e || DIV_e || MOD_e) && (state_q != CALC);

      case (state_q)
         CALC: begin
            cnt_d = cnt_q + 1'b1;
            if (op_q == OP_MUL) begin
               acc_d = mul_acc;
               b_d   = b_q >> 1;
            end else begin
               acc_d = {{(WIDTH-1){1'b0}}, rem_next};
               b_d   = quo_next;
            end
            if (cnt_q == LAST) begin
               state_d = DONE;
               cnt_d   = '0;
               case (op_q)
                  OP_MUL:  result_d = mul_acc[WIDTH-1:0];
                  OP_DIV:  result_d = quo_next;
                  default: result_d = rem_next[WIDTH-1:0];
               endcase
            end
         end
         DONE:    state_d = IDLE;
         default: ;
      endcase

      if (accept) begin
         op_d  = MUL_e ? OP_MUL : (DIV_e ? OP_DIV : OP_MOD);
         cnt_d = '0;
         acc_d = '0;
         if (MUL_e) begin
            a_d     = operand1;
            b_d     = operand2;
            state_d = CALC;
         end else begin
            a_d = operand2;
            b_d = operand1;
            if (operand2 == '0) begin
               state_d  = DONE;
               result_d = DIV_e ? {WIDTH{1'b1}} : operand1;
            end else begin
               state_d = CALC;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= OP_MUL;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         result_q <= result_d;
      end
   end

   assign busy   = (state_q == CALC);
   assign done   = (state_q == DONE);
   assign result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: self-checking bench for mul_div_unit.
// Directed scenarios plus randomized operations compared against an arithmetic reference.
module tb_mul_div_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [W-1:0] operand1 = '0;
   logic [W-1:0] operand2 = '0;
   logic         MUL_e = 1'b0;
   logic         DIV_e = 1'b0;
   logic         MOD_e = 1'b0;
   logic         start = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] result;

   int checks = 0;
   int errors = 0;

   mul_div_unit #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .operand1 (operand1),
      .operand2 (operand2),
      .MUL_e    (MUL_e),
      .DIV_e    (DIV_e),
      .MOD_e    (MOD_e),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .result   (result)
   );

   always #5 clk = ~clk;

   // Reference: plain unsigned arithmetic with enable priority MUL > DIV > MOD.
   function automatic logic [W-1:0] model(input bit m, input bit d, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      longint unsigned p;
      if (m) begin
         p = longint'(a) * longint'(b);
         return p[W-1:0];
      end
      if (d) return (b == 0) ? {W{1'b1}} : a / b;
      return (b == 0) ? a : a % b;
   endfunction

   function automatic int model_lat(input bit m, input logic [W-1:0] b);
      return (!m && b == 0) ? 0 : W;
   endfunction

   // Drive one start cycle, then scramble operands to prove they were latched.
   task automatic launch(input bit m, input bit d, input bit o, input logic [W-1:0] a,
                         input logic [W-1:0] b);
      @(negedge clk);
      operand1 = a;
      operand2 = b;
      MUL_e = m;
      DIV_e = d;
      MOD_e = o;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      MUL_e = 1'b0;
      DIV_e = 1'b0;
      MOD_e = 1'b0;
      operand1 = $urandom;
      operand2 = $urandom;
   endtask

   // Edges after the accepting edge until done is seen; -1 on timeout.
   task automatic wait_done(output int lat, output bit saw_busy);
      lat = 0;
      saw_busy = 1'b0;
      while (!done && lat < 100) begin
         if (busy) saw_busy = 1'b1;
         @(posedge clk);
         #1;
         lat++;
      end
      if (!done) lat = -1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++;
      if (result !== '0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if ({busy, done, result} !== '0) begin
            errors++;
            $display("FAIL idle_after_reset busy %b done %b result %h want 0 0 0", busy, done,
                     result);
         end
      end
   endtask

   task automatic test_directed();
      // m d o a b
      logic [W+W+2:0] vec [9] = '{
         {3'b100, 32'd7,          32'd6},
         {3'b010, 32'd100,        32'd7},
         {3'b001, 32'd100,        32'd7},
         {3'b100, 32'hFFFF_FFFF,  32'hFFFF_FFFF},
         {3'b010, 32'hFFFF_FFFF,  32'd1},
         {3'b001, 32'd5,          32'd9},
         {3'b010, 32'd123,        32'd0},
         {3'b001, 32'd123,        32'd0},
         {3'b110, 32'd3,          32'd4}
      };
      logic [W-1:0] want [9] = '{32'd42, 32'd14, 32'd2, 32'd1, 32'hFFFF_FFFF, 32'd5,
                                 32'hFFFF_FFFF, 32'd123, 32'd12};
      for (int i = 0; i < 9; i++) begin
         logic [W+W+2:0] v;
         int lat;
         bit sb;
         bit zero;
         v = vec[i];
         zero = !v[W+W+2] && (v[W-1:0] == 0);
         launch(v[W+W+2], v[W+W+1], v[W+W], v[W+W-1:W], v[W-1:0]);
         wait_done(lat, sb);
         checks++;
         if (result !== want[i]) begin
            errors++;
            $display("FAIL directed_%0d_result got %h want %h", i, result, want[i]);
         end
         checks++;
         if (lat != (zero ? 0 : W)) begin
            errors++;
            $display("FAIL directed_%0d_latency got %0d want %0d", i, lat, zero ? 0 : W);
         end
         checks++;
         if (sb !== !zero) begin
            errors++;
            $display("FAIL directed_%0d_busy_seen got %b want %b", i, sb, !zero);
         end
      end
   endtask

   task automatic test_no_enable();
      logic [W-1:0] prev;
      prev = result;
      launch(1'b0, 1'b0, 1'b0, 32'd5, 32'd6);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (busy !== 1'b0 || done !== 1'b0 || result !== prev) begin
            errors++;
            $display("FAIL no_enable busy %b done %b result %h want 0 0 %h", busy, done, result,
                     prev);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_ignored_start();
      int lat;
      bit sb;
      launch(1'b1, 1'b0, 1'b0, 32'd1234, 32'd5678);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      operand1 = 32'd9;
      operand2 = 32'd3;
      DIV_e = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      DIV_e = 1'b0;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL ignored_busy got %b want 1", busy); end
      wait_done(lat, sb);
      checks++;
      if (lat + 10 != W) begin
         errors++;
         $display("FAIL ignored_latency got %0d want %0d", lat + 10, W);
      end
      checks++;
      if (result !== 32'd7006652) begin
         errors++;
         $display("FAIL ignored_result got %h want %h", result, 32'd7006652);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      bit sb;
      launch(1'b1, 1'b0, 1'b0, 32'd7, 32'd6);
      wait_done(lat, sb);
      // Still inside the done cycle: request the next op here.
      operand1 = 32'd1000;
      operand2 = 32'd7;
      DIV_e = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      DIV_e = 1'b0;
      operand1 = $urandom;
      operand2 = $urandom;
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept done %b busy %b want 0 1", done, busy);
      end
      checks++;
      if (result !== 32'd42) begin
         errors++;
         $display("FAIL b2b_hold got %h want %h", result, 32'd42);
      end
      wait_done(lat, sb);
      checks++;
      if (lat != W || result !== 32'd142) begin
         errors++;
         $display("FAIL b2b_second lat %0d result %h want %0d %h", lat, result, W, 32'd142);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      bit sb;
      bit seen;
      launch(1'b0, 1'b1, 1'b0, 32'd1000, 32'd10);
      repeat (15) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
         errors++;
         $display("FAIL midreset busy %b done %b result %h want 0 0 0", busy, done, result);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done || busy) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL midreset_quiet got 1 want 0"); end
      launch(1'b0, 1'b1, 1'b0, 32'd1000, 32'd10);
      wait_done(lat, sb);
      checks++;
      if (lat != W || result !== 32'd100) begin
         errors++;
         $display("FAIL midreset_rerun lat %0d result %h want %0d %h", lat, result, W, 32'd100);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 25; i++) begin
         logic [2:0] en;
         logic [W-1:0] a, b, exp;
         int lat, elat;
         bit sb;
         en = 3'($urandom_range(1, 7));
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = '0;
            1:       b = W'($urandom_range(1, 15));
            default: b = $urandom;
         endcase
         exp = model(en[2], en[1], a, b);
         elat = model_lat(en[2], b);
         launch(en[2], en[1], en[0], a, b);
         wait_done(lat, sb);
         checks++;
         if (result !== exp || lat != elat) begin
            errors++;
            $display("FAIL random_%0d en %b a %h b %h result %h lat %0d want %h %0d", i, en, a,
                     b, result, lat, exp, elat);
         end
         @(posedge clk);
         #1;
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || result !== exp) begin
            errors++;
            $display("FAIL random_%0d_idle done %b busy %b result %h want 0 0 %h", i, done, busy,
                     result, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_no_enable();
      test_ignored_start();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative unsigned multiply/divide/modulo unit for the execute stage. It sits beside the single-cycle ALU and receives the same operands and one-hot `MUL_e`/`DIV_e`/`MOD_e` enables from the decoder. It computes the result over 32 cycles and returns it to writeback through a start/busy/done handshake. The decoder must hold the pipeline while `busy` is high.

## Interface
Parameters:
- WIDTH, 32, operand and result width; the iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- operand1  input  WIDTH  multiplicand / dividend.
- operand2  input  WIDTH  multiplier / divisor.
- MUL_e  input  1  select low-WIDTH product.
- DIV_e  input  1  select quotient.
- MOD_e  input  1  select remainder.
- start  input  1  request; sampled on the rising edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result becomes valid.
- result  output  WIDTH  registered result, held until the next accepted start.

## Operation
- All arithmetic is unsigned. Operands are latched at the accepting edge, so later operand changes have no effect.
- States:
  - IDLE: reset state.
  - CALC: iterating.
  - DONE: result valid.
- Accept rule: in IDLE or DONE, an edge with start=1 and at least one enable set is accepted.
  - start=1 with no enable set is ignored and the state is unchanged.
  - start in CALC is ignored.
- Enable priority when more than one enable is set: MUL_e > DIV_e > MOD_e. The selected op is latched at accept.
- MUL: shift-add. One multiplier bit is processed per cycle, LSB first. The accumulator is 2*WIDTH bits; result = low WIDTH bits of the product.
- DIV/MOD: restoring division. One dividend bit is shifted in per cycle, MSB first. A trial subtraction is made with a (WIDTH+1)-bit remainder. DIV returns the quotient; MOD returns the final remainder.
- Divide by zero (operand2 = 0 at accept, DIV or MOD):
  - No CALC phase; the accepting edge moves directly to DONE.
  - DIV result = all ones. MOD result = operand1.
- MUL by zero goes through the normal 32-iteration path; there is no early exit.
- Transitions:
  - IDLE → CALC on accept; operands latched, iteration counter cleared to 0.
  - CALC → CALC while counter < WIDTH-1, incrementing the counter.
  - CALC → DONE on the iteration where counter = WIDTH-1; result is registered.
  - DONE → CALC on accept (back-to-back op). DONE → IDLE otherwise.
- Reset (rst_n=0, any time including mid-CALC), asynchronous:
  - state = IDLE, counter = 0, internal accumulators = 0.
  - Outputs: busy = 0, done = 0, result = 0.
  - The in-flight op is discarded. No done pulse after release.

## Timing
- busy = 1 exactly while in CALC. done = 1 exactly while in DONE. busy and done are never both high.
- Latency, normal op: start accepted at edge k. busy is high from edge k to edge k+32. done and a valid result appear after edge k+WIDTH (k+32) for one cycle.
- Latency, divide by zero: done and result appear after edge k; busy never rises.
- Back-to-back: start may be high during the done cycle. The next op is then accepted at that edge, done drops, and busy rises. There are no idle bubbles.
- result changes only on the edge entering DONE, or on reset. It keeps its value through IDLE and through the following CALC.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset: hold rst_n=0 for 3 cycles → busy=0, done=0, result=0. Then release and leave start low for 5 cycles → outputs unchanged.
- MUL/DIV/MOD basics, each with start for one cycle:
  - MUL_e, 7×6 → done exactly 32 cycles after start, result=42.
  - DIV_e, 100/7 → result=14.
  - MOD_e, 100%7 → result=2.
- Width edges:
  - MUL 0xFFFFFFFF×0xFFFFFFFF → result=0x00000001.
  - DIV 0xFFFFFFFF/1 → 0xFFFFFFFF.
  - MOD 5%9 → 5.
- Divide by zero:
  - DIV 123/0 → done one cycle after start, busy never high, result=0xFFFFFFFF.
  - MOD 123%0 → result=123.
- Handshake:
  - start with no enables → no busy.
  - MUL_e+DIV_e together on 3,4 → result=12.
  - start with DIV 9/3 pulsed at cycle 10 of a MUL op → ignored; MUL result correct.
  - New start during the done cycle → accepted; second result correct 32 cycles later.
- Reset mid-op: assert rst_n=0 at iteration 15 of DIV 1000/10 → immediate busy=0, result=0, and no done pulse afterward. A fresh DIV 1000/10 then returns 100.
